// File: rtl/uart_arb_pkg.sv
// +--------------------------------------------------------------------+
// | uart_arb_pkg : shared types and helpers for the UART TX arbiter    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Index width that never collapses to zero, so a 1-bit index exists even for tiny counts.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// +--------------------------------------------------------------------+
// | rr_picker : combinational round-robin pick starting after rr_ptr   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [clog2(N_REQ)-1:0] rr_ptr,
  output logic                    pick_valid,
  output logic [clog2(N_REQ)-1:0] pick_idx
);

  localparam int IW = clog2(N_REQ);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic               w_found;
  int                 w_start;
  int                 w_off;
  int                 w_idx;

  always_comb begin
    w_start = (int'(rr_ptr) + 1) % N_REQ;
    w_dbl   = {req_valid, req_valid};
    w_rot   = N_REQ'(w_dbl >> w_start);
    w_found = 1'b0;
    w_off   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = k;
      end
    end
    w_idx      = (w_start + w_off) % N_REQ;
    pick_valid = w_found;
    pick_idx   = IW'(w_idx);
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +--------------------------------------------------------------------+
// | uart_tx_arbiter : packet-locking round-robin share of the UART TX  |
// | FIFO write port. Optional idle-owner release: UART_ARB_TIMEOUT_EN  |
// | (TIMEOUT_CYC >= 2 when enabled). Rev 1.0 - initial release         |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = uart_arb_pkg::DATA_W,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_full,
  output logic                      wr_uart,
  output logic [DATA_W-1:0]         w_data,
  output logic [clog2(N_REQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      timeout
);

  localparam int IW = clog2(N_REQ);
  localparam int BW = clog2(MAX_BURST);

  state_t          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   grant_q;
  logic            busy_q;
  logic [BW-1:0]   burst_q;
  logic [BW-1:0]   burst_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            xfer;
  logic            release_hit;
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr_q),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  // Write port is combinational so tx_full gates the strobe in the same cycle.
  always_comb begin
    xfer        = (state_q == LOCK) && req_valid[grant_q] && !tx_full;
    wr_uart     = xfer;
    req_ready   = xfer ? (N_REQ'(1) << grant_q) : '0;
    w_data      = (state_q == LOCK) ? data_arr[grant_q] : '0;
    burst_d     = burst_q + BW'(1);
    release_hit = req_last[grant_q] || (burst_q == BW'(MAX_BURST - 1));
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYC);

  logic [TW-1:0] idle_q;
  logic          timeout_q;
  logic          idle_now;
  logic          to_hit;

  // Release fires on the idle cycle that brings idle_cnt to TIMEOUT_CYC-1.
  always_comb begin
    idle_now = (state_q == LOCK) && !req_valid[grant_q] && !tx_full;
    to_hit   = idle_now && (idle_q == TW'(TIMEOUT_CYC - 2));
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IW'(N_REQ - 1);
      grant_q   <= '0;
      busy_q    <= 1'b0;
      burst_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            burst_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            idle_q  <= '0;
`endif
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
            idle_q <= '0;
`endif
            if (release_hit) begin
              rr_ptr_q <= grant_q;
              busy_q   <= 1'b0;
              burst_q  <= '0;
              state_q  <= IDLE;
            end else begin
              burst_q  <= burst_d;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (to_hit) begin
            rr_ptr_q  <= grant_q;
            busy_q    <= 1'b0;
            idle_q    <= '0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (idle_now) begin
            idle_q <= idle_q + TW'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO (wr_uart / w_data / tx_full) among N_REQ byte-stream requesters.
- Examples of requesters: the loopback-increment path, a status reporter and a debug dumper.
- Arbitration is round-robin with packet locking: once granted, a requester owns the FIFO write port until it flags the last byte or hits the burst limit.
- Sits in the clk_50MHz domain between the requesters and the uart unit.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width, matches the uart w_data width.
- MAX_BURST, 16, maximum bytes per grant before forced release (≥1).
- TIMEOUT_CYC, 1024, idle-owner cycles before lock release; used only with the optional feature.

Ports:
- clk, in, 1, system clock (clk_50MHz).
- reset, in, 1, asynchronous, active-low reset: 0 = reset.
- req_valid, in, N_REQ, per-requester byte available.
- req_data, in, N_REQ*DATA_W, requester i occupies bits [i*DATA_W +: DATA_W].
- req_last, in, N_REQ, qualifies req_data as the final byte of a packet.
- req_ready, out, N_REQ, byte of requester i accepted this cycle.
- tx_full, in, 1, uart TX FIFO full.
- wr_uart, out, 1, uart FIFO write strobe.
- w_data, out, DATA_W, uart FIFO write data.
- grant_id, out, clog2(N_REQ), current or last owner index.
- busy, out, 1, high while a lock is held.
- timeout, out, 1, one-cycle pulse on a timeout release (tied 0 without the macro).

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, rr_ptr=N_REQ-1, grant_id=0, burst_cnt=0, idle_cnt=0, busy=0, timeout=0. Combinational outputs are forced low in IDLE.
- FSM states: IDLE, LOCK.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from rr_ptr+1 upward, wrapping modulo N_REQ.
  - Register the pick as grant_id, set busy=1, clear burst_cnt, go to LOCK.
  - Arbitration costs exactly 1 cycle; no byte is transferred in IDLE.
- LOCK transfer condition: xfer = req_valid[grant_id] & ~tx_full.
  - wr_uart = xfer, req_ready = onehot(grant_id) & xfer, w_data = req_data[grant_id].
  - These are combinational, with zero latency, so FIFO overflow is impossible when tx_full reflects the current cycle.
- On xfer, burst_cnt increments.
- Release occurs on an xfer where req_last[grant_id]=1 or burst_cnt==MAX_BURST-1:
  - rr_ptr <= grant_id, busy <= 0, go to IDLE.
  - The next grant therefore goes to a different requester if one is valid.
- tx_full=1 in LOCK: stall, hold the lock, no timeout counting. Backpressure never breaks a packet.
- Owner drops req_valid mid-packet: the lock is held and other requesters wait. Packet atomicity takes precedence.
- Non-owner req_valid / req_last are ignored; their req_ready stays 0.
- Single requester continuously valid: it is re-granted after each release, with a 1-cycle IDLE bubble between bursts.
- MAX_BURST=1: release after every byte, giving byte-level round-robin.
- grant_id holds its value in IDLE until the next pick.
- Reset mid-LOCK aborts the packet immediately. Requesters must restart the packet; the arbiter keeps no partial state.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - In LOCK, idle_cnt counts cycles with req_valid[grant_id]=0 and tx_full=0, and clears on any xfer.
  - When idle_cnt reaches TIMEOUT_CYC-1: release the lock (rr_ptr <= grant_id, go to IDLE) and pulse timeout for 1 cycle.
- Not defined: idle_cnt is absent, timeout is tied 0, and the lock is held indefinitely.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, LOCK);
  - DATA_W default 8;
  - the grant-index width function clog2.
- One sub-module, rr_picker (combinational):
  - inputs: req_valid, rr_ptr;
  - outputs: pick_valid, pick_idx;
  - behaviour: rotate, priority-encode, un-rotate.
- FSM, counters and datapath mux stay in uart_tx_arbiter.

Test Plan:
- Reset release with req_valid=4'b0000 → wr_uart=0, busy=0, grant_id=0, req_ready=0 indefinitely.
- All 4 requesters valid, each sending a 3-byte packet (last on byte 3), tx_full=0:
  - grant order 0,1,2,3;
  - 12 writes with 1 idle cycle between packets;
  - w_data matches each requester's bytes in order.
- Requester 2 streams 20 bytes with no req_last, MAX_BURST=16, requester 0 also valid:
  - 16 bytes from 2, then 1 IDLE cycle, then grant_id=0.
- Requester 1 mid-packet, tx_full=1 for 5 cycles:
  - wr_uart=0 and busy=1 throughout;
  - the transfer resumes the cycle tx_full falls;
  - no byte is lost or duplicated.
- Requester 3 drops req_valid after byte 2, requester 0 valid:
  - without the macro: lock held, req_ready[0]=0 for 2000 cycles;
  - with UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: timeout pulses 8 cycles after the last xfer, then grant_id=0.
- reset asserted low mid-burst → all outputs return to reset values immediately (asynchronously); after release, arbitration restarts from requester 0.
